// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbiter and its siblings.
package uart_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   // Default UART data width.
   localparam int UART_DATA_BITS = 8;

   // Width of a requester index; never below one bit so a 2-way arbiter still has a real port.
   function automatic int grant_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin next-index finder: the first asserted request strictly after the
// last grant, wrapping modulo N. Purely combinational, so it can be shared with
// the receive-side dispatcher.
module rr_picker
   import uart_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = grant_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Walk the requesters starting one past the last grant; the first hit wins.
   always_comb begin
      valid = 1'b0;
      idx   = last;
      cand  = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IW'((int'(last) + i) % N);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte requesters.
// Owns the Tx_Data / Transmit_Start / Tx_Busy handshake; CTS gates new grants only.
// Optional start-timeout watchdog: define UART_ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | no byte in flight; grant when Req, CTS and transmitter idle
// START     | byte captured; strobe Transmit_Start until Tx_Busy rises
// WAIT_DONE | transmitter busy with the granted byte; wait for Tx_Busy to fall
//
// The grant cycle only captures Grant_Id and Tx_Data; the strobe rises on the
// following edge, so the transmitter always sees a settled byte under the strobe.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ       = 4,
   parameter  int DATA_BITS     = UART_DATA_BITS,
   parameter  int START_TIMEOUT = 16,
   localparam int GW            = grant_w(NUM_REQ)
) (
   input  logic                           Clk,
   input  logic                           Rst_n,
   input  logic [NUM_REQ-1:0]             Req,
   input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
   output logic [NUM_REQ-1:0]             Ack,
   output logic [NUM_REQ-1:0]             Done,
   input  logic                           CTS,
   output logic [DATA_BITS-1:0]           Tx_Data,
   output logic                           Transmit_Start,
   input  logic                           Tx_Busy,
   output logic [GW-1:0]                  Grant_Id,
   output logic                           Arb_Busy,
   output logic                           Timeout_Err
);

   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

   // Reject out-of-range configurations at elaboration.
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be 2..8");
   end
   if (DATA_BITS < 1 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_arbiter: DATA_BITS must be 1..8");
   end
   if (START_TIMEOUT < 1) begin : g_bad_timeout
      $error("uart_tx_arbiter: START_TIMEOUT must be at least 1");
   end

   state_t               state;
   logic                 pick_valid;
   logic [GW-1:0]        pick_idx;
   logic [DATA_BITS-1:0] pick_data;
   logic                 grant_ok;

   rr_picker #(
      .N  (NUM_REQ),
      .IW (GW)
   ) u_picker (
      .req   (Req),
      .last  (Grant_Id),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Byte of the requester the picker would grant this cycle.
   always_comb begin
      pick_data = Req_Data[pick_idx*DATA_BITS +: DATA_BITS];
   end

   assign grant_ok = pick_valid && CTS && !Tx_Busy;
   assign Arb_Busy = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);

   logic [TW-1:0] tmo_cnt;

   // Arbitration FSM with start-timeout watchdog; all outputs registered.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state          <= IDLE;
         Ack            <= '0;
         Done           <= '0;
         Tx_Data        <= '0;
         Transmit_Start <= 1'b0;
         Grant_Id       <= GW'(NUM_REQ - 1);
         Timeout_Err    <= 1'b0;
         tmo_cnt        <= '0;
      end else begin
         Ack  <= '0;
         Done <= '0;
         case (state)
            IDLE: begin
               if (grant_ok) begin
                  Grant_Id <= pick_idx;
                  Tx_Data  <= pick_data;
                  state    <= START;
               end
            end
            START: begin
               if (!Transmit_Start) begin
                  Transmit_Start <= 1'b1;
                  tmo_cnt        <= TW'(START_TIMEOUT - 1);
               end else if (Tx_Busy) begin
                  Transmit_Start <= 1'b0;
                  Ack            <= ONE_HOT_0 << Grant_Id;
                  state          <= WAIT_DONE;
               end else if (tmo_cnt == '0) begin
                  // Transmitter never answered: abandon the byte, keep the pointer.
                  Transmit_Start <= 1'b0;
                  Timeout_Err    <= 1'b1;
                  state          <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!Tx_Busy) begin
                  Done  <= ONE_HOT_0 << Grant_Id;
                  state <= IDLE;
               end
            end
            default: begin
               Transmit_Start <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end
`else
   assign Timeout_Err = 1'b0;

   // Arbitration FSM; START waits for Tx_Busy indefinitely. All outputs registered.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state          <= IDLE;
         Ack            <= '0;
         Done           <= '0;
         Tx_Data        <= '0;
         Transmit_Start <= 1'b0;
         Grant_Id       <= GW'(NUM_REQ - 1);
      end else begin
         Ack  <= '0;
         Done <= '0;
         case (state)
            IDLE: begin
               if (grant_ok) begin
                  Grant_Id <= pick_idx;
                  Tx_Data  <= pick_data;
                  state    <= START;
               end
            end
            START: begin
               if (!Transmit_Start) begin
                  Transmit_Start <= 1'b1;
               end else if (Tx_Busy) begin
                  Transmit_Start <= 1'b0;
                  Ack            <= ONE_HOT_0 << Grant_Id;
                  state          <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!Tx_Busy) begin
                  Done  <= ONE_HOT_0 << Grant_Id;
                  state <= IDLE;
               end
            end
            default: begin
               Transmit_Start <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_BITS=8).
// The bench plays the UART transmitter: it raises Tx_Busy after seeing
// Transmit_Start and drops it after a chosen frame length.
module tb_uart_tx_arbiter;

   logic        Clk;
   logic        Rst_n;
   logic [3:0]  Req;
   logic [31:0] Req_Data;
   logic [3:0]  Ack;
   logic [3:0]  Done;
   logic        CTS;
   logic [7:0]  Tx_Data;
   logic        Transmit_Start;
   logic        Tx_Busy;
   logic [1:0]  Grant_Id;
   logic        Arb_Busy;
   logic        Timeout_Err;

   uart_tx_arbiter #(
      .NUM_REQ       (4),
      .DATA_BITS     (8),
      .START_TIMEOUT (16)
   ) dut (
      .Clk            (Clk),
      .Rst_n          (Rst_n),
      .Req            (Req),
      .Req_Data       (Req_Data),
      .Ack            (Ack),
      .Done           (Done),
      .CTS            (CTS),
      .Tx_Data        (Tx_Data),
      .Transmit_Start (Transmit_Start),
      .Tx_Busy        (Tx_Busy),
      .Grant_Id       (Grant_Id),
      .Arb_Busy       (Arb_Busy),
      .Timeout_Err    (Timeout_Err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [1:0]  exp_id;
      logic [7:0]  exp_data;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   vec_t vecs[10];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push(input logic [1:0] id, input logic [7:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      sb.push_back(e);
   endtask

   // Act as the transmitter for one byte. mode: 0 keep Req, 1 clear Req at Ack,
   // 2 clear Req as soon as the strobe is seen. lat = edges until the strobe.
   task automatic serve(input int mode, input bit drop_cts, input int busy_len, output int lat);
      exp_t       e;
      logic [3:0] oh;
      lat = 0;
      while (!Transmit_Start && lat < 300) begin
         tick();
         lat++;
      end
      if (!Transmit_Start) begin
         chk("start_timeout", 32'd0, 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e  = sb.pop_front();
      oh = 4'b0001 << e.id;
      chk("grant_id", 32'(Grant_Id), 32'(e.id));
      chk("tx_data", 32'(Tx_Data), 32'(e.data));
      if (mode == 2) Req = 4'b0000;
      Tx_Busy = 1'b1;
      tick();
      chk("ack", 32'(Ack), 32'(oh));
      chk("start_drop", 32'(Transmit_Start), 32'd0);
      if (mode == 1) Req = 4'b0000;
      if (drop_cts) CTS = 1'b0;
      for (int n = 0; n < busy_len; n++) begin
         tick();
         if (n == 0) chk("ack_one_cycle", 32'(Ack), 32'd0);
      end
      chk("data_hold", 32'(Tx_Data), 32'(e.data));
      chk("no_early_done", 32'(Done), 32'd0);
      Tx_Busy = 1'b0;
      tick();
      chk("done", 32'(Done), 32'(oh));
      chk("done_no_start", 32'(Transmit_Start), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      bit ack_seen;

      // Pointer starts at 3, so the table below follows from round-robin order.
      vecs[0] = '{4'b0010, 32'h0000_A500, 2'd1, 8'hA5};
      vecs[1] = '{4'b1111, 32'h4433_2211, 2'd2, 8'h33};
      vecs[2] = '{4'b1111, 32'h4433_2211, 2'd3, 8'h44};
      vecs[3] = '{4'b1111, 32'h4433_2211, 2'd0, 8'h11};
      vecs[4] = '{4'b1001, 32'hD400_00D1, 2'd3, 8'hD4};
      vecs[5] = '{4'b0001, 32'h0000_005A, 2'd0, 8'h5A};
      vecs[6] = '{4'b0110, 32'h00C2_C100, 2'd1, 8'hC1};
      vecs[7] = '{4'b0001, 32'h0000_007E, 2'd0, 8'h7E};
      vecs[8] = '{4'b1000, 32'h8100_0000, 2'd3, 8'h81};
      vecs[9] = '{4'b0101, 32'h00B2_00B0, 2'd0, 8'hB0};

      Rst_n    = 1'b0;
      Req      = '0;
      Req_Data = '0;
      CTS      = 1'b1;
      Tx_Busy  = 1'b0;
      tick();
      tick();
      chk("rst_ack", 32'(Ack), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_tx_data", 32'(Tx_Data), 32'd0);
      chk("rst_start", 32'(Transmit_Start), 32'd0);
      chk("rst_grant_id", 32'(Grant_Id), 32'd3);
      chk("rst_arb_busy", 32'(Arb_Busy), 32'd0);
      chk("rst_timeout_err", 32'(Timeout_Err), 32'd0);
      Rst_n = 1'b1;
      tick();

      // Table: one byte per entry, requester drops Req on Ack.
      for (int i = 0; i < 10; i++) begin
         Req      = vecs[i].req;
         Req_Data = vecs[i].data;
         push(vecs[i].exp_id, vecs[i].exp_data);
         serve(1, 1'b0, 3, lat);
         chk("vec_latency", 32'(lat), 32'd2);
      end
      tick();
      chk("idle_after_table", 32'(Arb_Busy), 32'd0);

      // CTS low blocks grants; raising it grants two edges later.
      CTS      = 1'b0;
      Req      = 4'b0001;
      Req_Data = 32'h0000_005A;
      n = 0;
      repeat (100) begin
         tick();
         if (Transmit_Start) n++;
      end
      chk("cts_block_start", 32'(n), 32'd0);
      chk("cts_block_busy", 32'(Arb_Busy), 32'd0);
      CTS = 1'b1;
      push(2'd0, 8'h5A);
      serve(1, 1'b0, 3, lat);
      chk("cts_latency", 32'(lat), 32'd2);

      // CTS dropped mid-frame: frame completes, no new grant until CTS returns.
      Req      = 4'b0100;
      Req_Data = 32'h003C_0000;
      push(2'd2, 8'h3C);
      serve(1, 1'b1, 5, lat);
      Req      = 4'b0001;
      Req_Data = 32'h0000_005A;
      n = 0;
      repeat (20) begin
         tick();
         if (Transmit_Start) n++;
      end
      chk("cts_mid_no_grant", 32'(n), 32'd0);
      CTS = 1'b1;
      push(2'd0, 8'h5A);
      serve(1, 1'b0, 2, lat);
      chk("cts_mid_latency", 32'(lat), 32'd2);

      // Transmitter already busy while idle: no grant.
      Tx_Busy  = 1'b1;
      Req      = 4'b0010;
      Req_Data = 32'h0000_E100;
      n = 0;
      repeat (20) begin
         tick();
         if (Transmit_Start || Arb_Busy) n++;
      end
      chk("busy_idle_no_grant", 32'(n), 32'd0);
      Tx_Busy = 1'b0;
      push(2'd1, 8'hE1);
      serve(1, 1'b0, 2, lat);
      chk("busy_idle_latency", 32'(lat), 32'd2);

      // Continuous single requester re-granted; a newcomer is not starved.
      Req      = 4'b0100;
      Req_Data = 32'h00AB_00CD;
      push(2'd2, 8'hAB);
      push(2'd2, 8'hAB);
      serve(0, 1'b0, 2, lat);
      serve(0, 1'b0, 2, lat);
      chk("regrant_latency", 32'(lat), 32'd2);
      Req = 4'b0101;
      push(2'd0, 8'hCD);
      push(2'd2, 8'hAB);
      serve(0, 1'b0, 2, lat);
      chk("newcomer_latency", 32'(lat), 32'd2);
      serve(0, 1'b0, 2, lat);
      Req = 4'b0000;

      // Requester withdraws before Ack: captured byte still goes out.
      Req      = 4'b1000;
      Req_Data = 32'h9900_0000;
      push(2'd3, 8'h99);
      serve(2, 1'b0, 3, lat);

      // Fresh reset, then all four requesting: order 0,1,2,3,0.
      tick();
      #3 Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1;
      Req      = 4'b1111;
      Req_Data = 32'h4433_2211;
      push(2'd0, 8'h11);
      push(2'd1, 8'h22);
      push(2'd2, 8'h33);
      push(2'd3, 8'h44);
      push(2'd0, 8'h11);
      for (int k = 0; k < 5; k++) begin
         serve(0, 1'b0, 2, lat);
         chk("all4_latency", 32'(lat), 32'd2);
      end
      Req = 4'b0000;

      // Asynchronous reset while in WAIT_DONE.
      Req      = 4'b0100;
      Req_Data = 32'h0077_0000;
      tick();
      tick();
      chk("wd_start", 32'(Transmit_Start), 32'd1);
      Tx_Busy = 1'b1;
      tick();
      chk("wd_ack", 32'(Ack), 32'b0100);
      tick();
      #3 Rst_n = 1'b0;
      #1;
      chk("async_ack", 32'(Ack), 32'd0);
      chk("async_done", 32'(Done), 32'd0);
      chk("async_tx_data", 32'(Tx_Data), 32'd0);
      chk("async_start", 32'(Transmit_Start), 32'd0);
      chk("async_grant_id", 32'(Grant_Id), 32'd3);
      chk("async_arb_busy", 32'(Arb_Busy), 32'd0);
      Tx_Busy = 1'b0;
      tick();
      tick();
      Rst_n = 1'b1;
      push(2'd2, 8'h77);
      serve(1, 1'b0, 2, lat);
      chk("post_reset_latency", 32'(lat), 32'd2);

      // Transmitter never answers the strobe.
      Req      = 4'b0001;
      Req_Data = 32'h0000_0042;
      tick();
      tick();
      chk("stuck_start", 32'(Transmit_Start), 32'd1);
      chk("stuck_grant_id", 32'(Grant_Id), 32'd0);
      chk("stuck_tx_data", 32'(Tx_Data), 32'h42);
      n = 1;
      ack_seen = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      while (n < 200) begin
         tick();
         if (|Ack) ack_seen = 1'b1;
         if (!Transmit_Start) break;
         n++;
      end
      Req = 4'b0000;
      chk("tmo_strobe_len", 32'(n), 32'd16);
      chk("tmo_err_set", 32'(Timeout_Err), 32'd1);
      chk("tmo_no_ack", 32'(ack_seen), 32'd0);
      chk("tmo_idle", 32'(Arb_Busy), 32'd0);
      repeat (4) tick();
      chk("tmo_err_sticky", 32'(Timeout_Err), 32'd1);
      chk("tmo_no_done", 32'(Done), 32'd0);
`else
      repeat (99) begin
         tick();
         if (|Ack) ack_seen = 1'b1;
         if (Transmit_Start) n++;
      end
      chk("no_tmo_strobe_len", 32'(n), 32'd100);
      chk("no_tmo_err", 32'(Timeout_Err), 32'd0);
      chk("no_tmo_no_ack", 32'(ack_seen), 32'd0);
      Tx_Busy = 1'b1;
      tick();
      chk("late_ack", 32'(Ack), 32'b0001);
      Req = 4'b0000;
      tick();
      Tx_Busy = 1'b0;
      tick();
      chk("late_done", 32'(Done), 32'b0001);
`endif

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
